// File: rtl/flag_unit_pipe.sv
// Two-stage flag unit: stage 1 captures partial ORs and flag sources of the ALU result,
// stage 2 reduces them to Z, updates NZCV and resolves B.cond / CBZ / CBNZ.
module flag_unit_pipe #(
   parameter int WIDTH = 64,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] result,
   input  logic             carry_in,
   input  logic             overflow_in,
   input  logic             set_flags,
   input  logic [1:0]       br_kind,
   input  logic [3:0]       cond,
   output logic [3:0]       flags,
   output logic             zero_out,
   output logic             take_branch,
   output logic             valid_out
);

   localparam int NP   = WIDTH / GROUP;
   localparam int NG   = (NP + GROUP - 1) / GROUP;
   localparam int NPAD = NG * GROUP;

   function automatic int num_levels(input int n);
      int cnt;
      int l;
      cnt = n;
      l   = 0;
      while (cnt > 1) begin
         cnt = (cnt + GROUP - 1) / GROUP;
         l++;
      end
      return l;
   endfunction

   localparam int LEVELS = num_levels(NP);

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      logic res;
      {n, z, cy, v} = f;
      case (c)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = cy;
         4'b0011: res = ~cy;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = cy & ~z;
         4'b1001: res = ~cy | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   logic          s1_valid;
   logic [NP-1:0] s1_part;
   logic          s1_n, s1_c, s1_v, s1_set;
   logic [1:0]    s1_br;
   logic [3:0]    s1_cond;

   logic [NP-1:0] part;
   logic          z_new;

   always_comb begin
      part = '0;
      for (int k = 0; k < NP; k++) begin
         part[k] = |result[k*GROUP +: GROUP];
      end
   end

   // Zero detect as a tree: each level ORs GROUP-wide slices, padding bits stay 0.
   always_comb begin
      logic [NPAD-1:0] cur;
      logic [NPAD-1:0] nxt;
      cur          = '0;
      cur[NP-1:0]  = s1_part;
      for (int l = 0; l < LEVELS; l++) begin
         nxt = '0;
         for (int j = 0; j < NG; j++) begin
            nxt[j] = |cur[j*GROUP +: GROUP];
         end
         cur = nxt;
      end
      z_new = ~cur[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_part  <= '0;
         s1_n     <= 1'b0;
         s1_c     <= 1'b0;
         s1_v     <= 1'b0;
         s1_set   <= 1'b0;
         s1_br    <= 2'b00;
         s1_cond  <= 4'b0000;
      end else begin
         s1_valid <= valid_in;
         s1_part  <= part;
         s1_n     <= result[WIDTH-1];
         s1_c     <= carry_in;
         s1_v     <= overflow_in;
         s1_set   <= set_flags & valid_in;
         s1_br    <= valid_in ? br_kind : 2'b00;
         s1_cond  <= cond;
      end
   end

   // B.cond reads flags before this edge's write; the previous instruction has already landed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags       <= 4'b0000;
         zero_out    <= 1'b0;
         take_branch <= 1'b0;
         valid_out   <= 1'b0;
      end else begin
         valid_out <= s1_valid;
         zero_out  <= z_new;
         if (s1_set) begin
            flags <= {s1_n, z_new, s1_c, s1_v};
         end
         case (s1_br)
            2'b01:   take_branch <= cond_holds(s1_cond, flags);
            2'b10:   take_branch <= z_new;
            2'b11:   take_branch <= ~z_new;
            default: take_branch <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_unit_pipe.sv
// Self-checking bench for flag_unit_pipe: directed steps with a scoreboard of
// {valid_out, zero_out, take_branch, flags} expected two edges after each drive.
module tb_flag_unit_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [63:0] result;
   logic        carry_in;
   logic        overflow_in;
   logic        set_flags;
   logic [1:0]  br_kind;
   logic [3:0]  cond;
   logic [3:0]  flags;
   logic        zero_out;
   logic        take_branch;
   logic        valid_out;

   typedef struct packed {
      logic       v;
      logic       z;
      logic       t;
      logic [3:0] f;
   } exp_t;

   exp_t       sb[$];
   string      sbTag[$];
   logic [3:0] modelFlags;
   int         total  = 0;
   int         passed = 0;
   int         failed = 0;

   flag_unit_pipe #(.WIDTH(64), .GROUP(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .result      (result),
      .carry_in    (carry_in),
      .overflow_in (overflow_in),
      .set_flags   (set_flags),
      .br_kind     (br_kind),
      .cond        (cond),
      .flags       (flags),
      .zero_out    (zero_out),
      .take_branch (take_branch),
      .valid_out   (valid_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference condition table, written straight from the NZCV definitions.
   function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return cy;
         4'd3:    return !cy;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return cy && !z;
         4'd9:    return !cy || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t  e;
      string t;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         t = sbTag.pop_front();
         check(t, {valid_out, zero_out, take_branch, flags}, e);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] r, input logic c,
                                input logic o, input logic s, input logic [1:0] b,
                                input logic [3:0] cd, input string tag);
      exp_t e;
      e.v = v;
      e.z = (r == 64'd0);
      e.t = 1'b0;
      if (v) begin
         case (b)
            2'b01:   e.t = condModel(cd, modelFlags);
            2'b10:   e.t = e.z;
            2'b11:   e.t = !e.z;
            default: e.t = 1'b0;
         endcase
         if (s) modelFlags = {r[63], (r == 64'd0), c, o};
      end
      e.f = modelFlags;
      valid_in    = v;
      result      = r;
      carry_in    = c;
      overflow_in = o;
      set_flags   = s;
      br_kind     = b;
      cond        = cd;
      sb.push_back(e);
      sbTag.push_back(tag);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic bubble(input string tag);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, tag);
   endtask

   initial begin
      logic [63:0] r;
      reset       = 1'b1;
      valid_in    = 1'b0;
      result      = '0;
      carry_in    = 1'b0;
      overflow_in = 1'b0;
      set_flags   = 1'b0;
      br_kind     = 2'b00;
      cond        = 4'd0;
      modelFlags  = 4'b0000;
      #12;
      check("reset_state", {valid_out, zero_out, take_branch, flags}, 7'd0);
      reset = 1'b0;

      applyStimulus(1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, "zero_set_flags");
      applyStimulus(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, "neg_set_flags");
      check("first_flags_0110", {3'b000, flags}, {3'b000, 4'b0110});
      applyStimulus(1'b1, 64'd123, 1'b1, 1'b1, 1'b0, 2'b01, 4'b1011, "bcond_lt");
      check("neg_flags_1000", {3'b000, flags}, {3'b000, 4'b1000});
      applyStimulus(1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0, "cbz_nonzero");
      check("lt_taken", {6'd0, take_branch}, 7'd1);
      applyStimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0, "cbz_zero");
      applyStimulus(1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, "cbnz_nonzero");
      applyStimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, "cbnz_zero");
      applyStimulus(1'b0, 64'd5, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0, "invalid_set_ignored");

      applyStimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, "load_0100");
      for (int i = 0; i < 5; i++) bubble("bubble_hold");
      applyStimulus(1'b1, 64'd77, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, "beq_after_bubbles");

      for (int f = 0; f < 16; f++) begin
         if (f[3] && f[2]) continue;
         if (f[2]) r = 64'd0;
         else if (f[3]) r = {1'b1, 31'($urandom), 32'($urandom)};
         else r = {1'b0, 31'($urandom), 32'($urandom)} | 64'd1;
         applyStimulus(1'b1, r, f[1], f[0], 1'b1, 2'b00, 4'd0, $sformatf("sweep_load_%b", 4'(f)));
         for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, {32'($urandom), 32'($urandom)}, 1'($urandom), 1'($urandom),
                          1'b0, 2'b01, 4'(c), $sformatf("sweep_f%b_c%b", 4'(f), 4'(c)));
         end
      end

      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 2'b00, 4'd0, "pre_reset_set");
      #2;
      reset = 1'b1;
      #1;
      check("reset_async", {valid_out, zero_out, take_branch, flags}, 7'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      sb.delete();
      sbTag.delete();
      modelFlags = 4'b0000;
      bubble("post_reset_bubble");
      check("post_reset_clean", {3'b000, valid_out, flags[2:0]}, 7'd0);
      check("post_reset_flags", {2'b00, take_branch, flags}, 7'd0);

      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 2'b00, 4'd0, "b2b_set");
      applyStimulus(1'b1, 64'd9, 1'b0, 1'b0, 1'b0, 2'b01, 4'b1010, "b2b_bcond_ge");
      applyStimulus(1'b1, 64'd9, 1'b0, 1'b0, 1'b0, 2'b01, 4'b1100, "b2b_bcond_gt");
      bubble("flush0");
      bubble("flush1");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/flag_unit_pipe.md
Name: flag_unit_pipe

Overview:
- Two-stage pipelined consumer of the ALU result bus.
- Stage 1 registers 4-bit partial ORs of the result, plus the N, C and V sources.
- Stage 2 reduces the partials to Z, conditionally latches the architectural NZCV register, and resolves branch decisions (B.cond, CBZ, CBNZ).
- Sits between the ALU and the branch/PC-select logic of the 64-bit LEGv8 datapath.

Parameters:
- WIDTH, 64, ALU result width; must be a multiple of GROUP.
- GROUP, 4, bits per partial-OR group; also the fan-in limit per gate. Partial count NP = WIDTH/GROUP (16 by default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- valid_in  input  1  result/control inputs are meaningful this cycle.
- result  input  WIDTH  ALU result.
- carry_in  input  1  ALU carry-out for this result.
- overflow_in  input  1  ALU signed overflow for this result.
- set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- br_kind  input  2  00 none, 01 B.cond, 10 CBZ, 11 CBNZ.
- cond  input  4  condition code for B.cond.
- flags  output  4  architectural NZCV register, {N,Z,C,V}.
- zero_out  output  1  Z of the stage-2 instruction's own result.
- take_branch  output  1  branch resolved taken.
- valid_out  output  1  stage-2 outputs meaningful.

Behaviour:
- Reset (async, any time): stage-1 registers, NZCV, zero_out, take_branch and valid_out all go to 0. In-flight instructions are discarded; no flag write happens for them. The first valid result after reset deasserts is handled normally.
- Stage 1, edge E0:
  - s1_valid <= valid_in.
  - s1_part[k] <= |result[k*GROUP +: GROUP] for k = 0..NP-1.
  - s1_n <= result[WIDTH-1], s1_c <= carry_in, s1_v <= overflow_in.
  - s1_set <= set_flags & valid_in, s1_br <= valid_in ? br_kind : 00, s1_cond <= cond.
- Stage 2, edge E1:
  - Compute z_new = ~|s1_part, reduced through gates of at most GROUP inputs.
  - zero_out <= z_new; valid_out <= s1_valid.
  - If s1_set, flags <= {s1_n, z_new, s1_c, s1_v}; otherwise flags hold.
  - Latency: inputs at E0 produce outputs and flags visible after E1, i.e. 2 edges.
- Branch resolution at E1 (take_branch is a registered output):
  - s1_br=00: 0.
  - s1_br=10: z_new.
  - s1_br=11: ~z_new.
  - s1_br=01: cond evaluated on flags as held *before* this edge. The prior instruction has already written at the previous edge, so no forwarding is needed. An instruction cannot both set flags and use B.cond.
- Condition codes (N, Z, C, V = current flags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 HS C; 0011 LO ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 AL 1.
- Bubbles: valid_in=0 gives no flag write, valid_out=0 and take_branch=0 two edges later. Flags hold across any number of bubbles.
- set_flags with valid_in=0 is ignored. br_kind with valid_in=0 is ignored.
- Back-to-back: a flag-setting instruction at cycle t followed by B.cond at t+1 sees the new flags.
- zero_out updates for every valid result, regardless of set_flags.

Test Plan:
- Reset, then valid_in=1, set_flags=1, result=0, carry_in=1, overflow_in=0 -> after 2 edges flags=0110, zero_out=1, valid_out=1.
- Result=64'h8000_0000_0000_0000 with set_flags=1, next cycle B.cond cond=1011 (LT), V=0 -> flags=1000; B.cond cycle take_branch=1.
- Result=64'h0000_0000_0001_0000, set_flags=0, br_kind=10 (CBZ) -> zero_out=0, take_branch=0, flags unchanged. Repeat with result=0 -> take_branch=1. Repeat with br_kind=11 -> inverse outcome.
- Sweep all 16 cond values against each NZCV combination loaded via set_flags -> take_branch matches the condition table; 1110 and 1111 are always 1.
- Flags=0100 loaded, then 5 bubble cycles, then B.cond EQ -> flags stay 0100 throughout, valid_out=0 during bubbles, take_branch=1 on the B.cond.
- Assert reset mid-pipeline while a set_flags instruction is in stage 1 -> flags=0000 and all outputs 0 immediately; after release, no stale flag write or valid_out pulse appears.
